// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side consumer for an async FIFO.
// Pulls words with rd_en and re-presents them as a valid/ready stream
// through a small circular skid buffer. The buffer also frames the stream
// into bursts via m_last, and the block keeps a read counter and a sticky
// error flag.
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  busy,
    output logic                  err
);

    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]           state_q,    state_d;
    logic [OCC_W-1:0]     occ_q,      occ_d;
    logic                 inflight_q, inflight_d;
    logic [BEAT_W-1:0]    beat_q,     beat_d;
    logic [PTR_W-1:0]     head_q,     head_d;
    logic [PTR_W-1:0]     tail_q,     tail_d;
    logic [CNT_WIDTH-1:0] words_q,    words_d;
    logic                 err_q,      err_d;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

    logic             pop;
    logic             push;
    logic [OCC_W:0]   level;

    // Advance a buffer pointer, wrapping at BUF_DEPTH (need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Advance the beat counter, wrapping after the final beat of a frame.
    function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] b);
        return (b == BEAT_W'(BURST_LEN - 1)) ? '0 : b + BEAT_W'(1);
    endfunction

    // Stream handshake, capture qualification and the FIFO read request.
    always_comb begin
        m_valid = (occ_q != '0);
        pop     = m_valid && m_ready;
        // A returning word is only kept when we asked for it and are not discarding.
        push    = fifo_valid && inflight_q && (state_q != ST_FLUSH) && !flush;
        // Words already held or on their way, net of the one leaving this cycle.
        level   = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
        // Suppressed during rst so no word is pulled out of the FIFO only to be dropped.
        rd_en   = !rst && (state_q == ST_RUN) && !fifo_empty
                  && (level < (OCC_W + 1)'(BUF_DEPTH));
    end

    // Next-state logic for the controller, buffer bookkeeping and counters.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        beat_d     = beat_q;
        head_d     = head_q;
        tail_d     = tail_q;
        words_d    = words_q + CNT_WIDTH'(rd_en);
        err_d      = err_q | (fifo_valid && !inflight_q);

        case (state_q)
            ST_IDLE: begin
                if (flush)       state_d = ST_FLUSH;
                else if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)        state_d = ST_FLUSH;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!inflight_q && !flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request wins over a completing one, so overlap keeps inflight at 1.
        if (rd_en)           inflight_d = 1'b1;
        else if (fifo_valid) inflight_d = 1'b0;

        if (flush) begin
            // Drop buffered words and restart framing at beat 0.
            occ_d  = '0;
            head_d = '0;
            tail_d = '0;
            beat_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
            if (push) tail_d = ptr_inc(tail_q);
            if (pop) begin
                head_d = ptr_inc(head_q);
                beat_d = beat_inc(beat_q);
            end
        end
    end

    // Control and counter registers with synchronous reset.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            words_q    <= words_d;
            err_q      <= err_d;
        end
    end

    // Skid-buffer storage: each entry loads when the tail points at it.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        always_ff @(posedge rd_clk) begin
            if (push && (tail_q == PTR_W'(gi))) mem[gi] <= fifo_data;
        end
    end

    // Output view; data is forced to zero when nothing is buffered.
    always_comb begin
        m_data     = m_valid ? mem[head_q] : '0;
        m_last     = m_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
        words_read = words_q;
        busy       = (state_q != ST_IDLE) || (occ_q != '0) || inflight_q;
        err        = err_q;
    end

endmodule
